// File: rtl/result_display_pkg.sv
// result_display_pkg: shared definitions for the result_display slice.
//   state_t       - controller states (IDLE / CONVERT / SHOW)
//   SEG_BLANK     - all segments off (active-low)
//   SEG_TABLE     - active-low gfedcba patterns for digits 0..9
//   BCD_STEPS     - double-dabble iterations for a 4-bit operand
//   dd_step()     - one double-dabble step on an {8-bit BCD, 4-bit binary} pair
package result_display_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      CONVERT = 2'b01,
      SHOW    = 2'b10
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Entry [n] is the pattern for digit n (listed 9 down to 0).
   localparam logic [9:0][6:0] SEG_TABLE = {
      7'b0010000,  // 9
      7'b0000000,  // 8
      7'b1111000,  // 7
      7'b0000010,  // 6
      7'b0010010,  // 5
      7'b0011001,  // 4
      7'b0110000,  // 3
      7'b0100100,  // 2
      7'b1111001,  // 1
      7'b1000000   // 0
   };

   localparam int BCD_STEPS = 4;
   localparam logic [1:0] LAST_STEP = 2'(BCD_STEPS - 1);

   // Add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by one.
   // Returns the new {bcd[7:0], bin[3:0]}.
   function automatic logic [11:0] dd_step(input logic [7:0] bcd, input logic [3:0] bin);
      logic [7:0] adj;
      adj = bcd;
      if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
      if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;
      return {adj[6:0], bin, 1'b0};
   endfunction

endpackage

// File: rtl/result_display_if.sv
// result_display_if: divider-result / display bundle.
//   S, R   - quotient and remainder (0..15)
//   load   - one-cycle strobe, S/R valid
//   seg    - active-low segments {g,f,e,d,c,b,a}
//   an     - active-low digit enables (an[3]=S tens .. an[0]=R units)
//   busy   - conversion in progress
//   ready  - converted result on display
// master: result producer side; slave: the display block.
interface result_display_if;
   logic [3:0] S;
   logic [3:0] R;
   logic       load;
   logic [6:0] seg;
   logic [3:0] an;
   logic       busy;
   logic       ready;

   modport master (output S, output R, output load,
                   input seg, input an, input busy, input ready);
   modport slave  (input S, input R, input load,
                   output seg, output an, output busy, output ready);
endinterface

// File: rtl/result_display_seg7_decoder.sv
// seg7_decoder: combinational digit to active-low 7-segment pattern.
//   digit - BCD digit; 10..15 produce a blank pattern
//   blank - force all segments off
//   seg   - {g,f,e,d,c,b,a}, active-low
module seg7_decoder
   import result_display_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (!blank && digit <= 4'd9)
         seg = SEG_TABLE[digit];
   end

endmodule

// File: rtl/result_display.sv
// result_display: captures divider quotient S / remainder R on load, converts
// both to two BCD digits with a 4-step shift-add-3 engine, and scans the four
// digits onto a common-anode 7-segment display.
//   clk   - system clock, rising edge
//   reset - asynchronous, active-high
//   bus   - result_display_if.slave (S, R, load in; seg, an, busy, ready out)
// Parameters: REFRESH_DIV cycles per lit digit (>= 2), CNT_W refresh counter width.
module result_display
   import result_display_pkg::*;
#(
   parameter int REFRESH_DIV = 50000,
   parameter int CNT_W       = 16
) (
   input  logic           clk,
   input  logic           reset,
   result_display_if.slave bus
);

   state_t           state;
   logic [1:0]       iter;
   logic             busy_r, ready_r;
   logic [3:0]       s_sh, r_sh;
   logic [7:0]       s_bcd, r_bcd;
   logic [3:0][3:0]  disp;       // [3]=S tens, [2]=S units, [1]=R tens, [0]=R units
   logic [3:0]       blank;
   logic             shown;      // a result has been committed since reset
   logic [CNT_W-1:0] cnt;
   logic [1:0]       idx;
   logic [6:0]       seg_r;
   logic [3:0]       an_r;

   logic [11:0]      s_step, r_step;
   logic             start, commit, wrap, shown_nxt;
   logic [3:0][3:0]  disp_nxt;
   logic [3:0]       blank_nxt;
   logic [1:0]       idx_nxt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [6:0]       seg_pat;
   logic [3:0]       an_nxt;

   // Loads arriving during CONVERT are dropped so the operands in flight survive.
   assign start  = bus.load && (state != CONVERT);
   assign commit = (state == CONVERT) && (iter == LAST_STEP);
   assign s_step = dd_step(s_bcd, s_sh);
   assign r_step = dd_step(r_bcd, r_sh);

   // Outputs are built from next-state values so the committed digits appear
   // on the commit edge and an/seg always switch together.
   always_comb begin
      disp_nxt  = disp;
      blank_nxt = blank;
      if (commit) begin
         disp_nxt  = {s_step[11:8], s_step[7:4], r_step[11:8], r_step[7:4]};
         blank_nxt = {(s_step[11:8] == 4'd0), 1'b0, (r_step[11:8] == 4'd0), 1'b0};
      end
      shown_nxt = shown | commit;
      wrap      = (cnt == CNT_W'(REFRESH_DIV - 1));
      cnt_nxt   = wrap ? '0 : cnt + CNT_W'(1);
      idx_nxt   = wrap ? idx + 2'd1 : idx;
      an_nxt    = shown_nxt ? ~(4'b0001 << idx_nxt) : 4'b1111;
   end

   seg7_decoder u_dec (
      .digit (disp_nxt[idx_nxt]),
      .blank (blank_nxt[idx_nxt]),
      .seg   (seg_pat)
   );

   // Controller, scan and display registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         iter    <= 2'd0;
         busy_r  <= 1'b0;
         ready_r <= 1'b0;
         disp    <= '0;
         blank   <= 4'b1111;
         shown   <= 1'b0;
         cnt     <= '0;
         idx     <= 2'd0;
         an_r    <= 4'b1111;
         seg_r   <= SEG_BLANK;
      end else begin
         case (state)
            IDLE, SHOW: begin
               if (bus.load) begin
                  iter    <= 2'd0;
                  busy_r  <= 1'b1;
                  ready_r <= 1'b0;
                  state   <= CONVERT;
               end
            end
            CONVERT: begin
               iter <= iter + 2'd1;
               if (commit) begin
                  busy_r  <= 1'b0;
                  ready_r <= 1'b1;
                  state   <= SHOW;
               end
            end
            default: state <= IDLE;
         endcase
         disp  <= disp_nxt;
         blank <= blank_nxt;
         shown <= shown_nxt;
         cnt   <= cnt_nxt;
         idx   <= idx_nxt;
         an_r  <= an_nxt;
         seg_r <= shown_nxt ? seg_pat : SEG_BLANK;
      end
   end

   // Double-dabble datapath: only meaningful while CONVERT, so no reset needed.
   always_ff @(posedge clk) begin
      if (start) begin
         s_sh  <= bus.S;
         r_sh  <= bus.R;
         s_bcd <= 8'd0;
         r_bcd <= 8'd0;
      end else if (state == CONVERT) begin
         {s_bcd, s_sh} <= s_step;
         {r_bcd, r_sh} <= r_step;
      end
   end

   assign bus.seg   = seg_r;
   assign bus.an    = an_r;
   assign bus.busy  = busy_r;
   assign bus.ready = ready_r;

endmodule

// File: doc/result_display.md
Name: result_display

Overview:
Downstream stage of the 4-bit divider. It captures the quotient S and remainder R when a result-valid pulse arrives. It converts each value to two BCD digits with a sequential shift-add-3 engine, then time-multiplexes the four digits onto a common-anode 4-digit 7-segment display. It is the block that makes the calculator's division result visible on the board.

Parameters:
REFRESH_DIV, 50000, clock cycles each digit stays lit before the scan advances (min 2)
CNT_W, 16, width of the refresh counter; must hold REFRESH_DIV-1

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
S  input  4  quotient from divider, unsigned 0..15
R  input  4  remainder from divider, unsigned 0..15
load  input  1  single-cycle pulse: S/R valid this cycle
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
an  output  4  digit enables, active-low; an[3]=S tens, an[2]=S units, an[1]=R tens, an[0]=R units
busy  output  1  high while conversion in progress
ready  output  1  high once a converted result is on display

Behaviour:
- Reset is asynchronous and active-high.
  - Reset values: seg=7'b1111111, an=4'b1111, busy=0, ready=0.
  - State returns to IDLE; scan index=0; refresh counter=0; display digit registers cleared; blank flags set.
- States:
  - IDLE: display blanked (an=1111, seg=1111111).
  - CONVERT: busy=1.
  - SHOW: scanning active, ready=1.
- Transitions:
  - IDLE or SHOW, load=1 at an edge: latch S and R into shift registers, clear the BCD accumulators, set iteration counter=0, go to CONVERT.
  - CONVERT: one double-dabble step per clock, on S and R in parallel. Each step adds 3 to any BCD nibble >=5, then shifts left by 1.
  - CONVERT, at the edge where iteration counter==3: commit both BCD pairs to the display registers and go to SHOW.
  - SHOW: stays in SHOW until reset or load.
- Latency: busy is high for exactly 4 cycles after the load edge. ready rises on the 5th edge, and the new digits are displayed from that edge.
- load while in CONVERT is ignored. The operands in flight are not disturbed.
- load while in SHOW:
  - ready drops to 0 and busy rises to 1.
  - The previous digits stay on the display, and scanning continues, until the commit.
- Leading-zero blanking: a tens digit equal to 0 is shown blank (seg=1111111, its an line still asserted). Units digits are always shown, so 0 displays as "0".
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - When it wraps, scan index increments 0→1→2→3→0.
  - Index i asserts an[i] low only; exactly one an bit is low in SHOW and CONVERT-after-SHOW.
  - an and seg are registered and change on the same edge (no ghosting).
- Segment encoding, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Width rules: input range 0..15, so the tens digit is 0 or 1. BCD accumulators are 8 bits per value. No overflow is possible.
- Reset mid-CONVERT: abort immediately to reset values. No partial digits ever reach the display.

Decomposition:
- Shared package:
  - state encoding constants (IDLE=2'b00, CONVERT=2'b01, SHOW=2'b10)
  - SEG_BLANK=7'b1111111
  - digit-to-segment constant table 0..9
  - BCD_STEPS=4
- One natural sub-module: seg7_decoder. It is combinational: 4-bit digit plus blank flag in, 7-bit active-low pattern out. It is instantiated once, after the scan mux. Values 10..15 map to SEG_BLANK.

Test Plan:
1. Assert reset for 3 cycles, then release with no load → an=1111, seg=1111111, busy=0, ready=0 for 100 cycles.
2. REFRESH_DIV=4; S=7, R=1, load pulse → busy=1 for exactly 4 cycles, ready=1 on the 5th edge. Scan shows:
   - an=1110 with seg=1111001
   - an=1101 with seg blank
   - an=1011 with seg=1111000
   - an=0111 with seg blank
   - each digit held 4 cycles, sequence wraps every 16 cycles.
3. S=15, R=12, load → digits shown:
   - an[3]: "1" (1111001)
   - an[2]: "5" (0010010)
   - an[1]: "1" (1111001)
   - an[0]: "2" (0100100)
4. From SHOW of S=15/R=12: load S=0/R=3, then a second load S=9/R=9 two cycles later → the second load is ignored. The old digits persist during busy. The final display is 0 (1000000) and 3 (0110000), with both tens blank.
5. load S=10/R=0, then assert reset 2 cycles into CONVERT → all outputs at reset values immediately, asynchronously. After release, the state is IDLE and the display stays blank.
6. S=0, R=0, load → units digits show 1000000 and tens digits blank. ready=1 and busy=0 afterward.
